// File: rtl/simon_datapath_param.sv
// Simon pattern datapath with parametrised LED width and memory depth.
// Holds the entered sequence, level legality check and a self-timed replay engine.
module simon_datapath_param #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 64,
    parameter int PLAY_TICKS = 8,
    parameter int GAP_TICKS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             level,
    input  logic             set_level,
    input  logic [WIDTH-1:0] pattern,
    input  logic             w_en,
    input  logic             read_memory,
    input  logic             cnt_count,
    input  logic             clr_count,
    input  logic             cnt_index,
    input  logic             clr_index,
    input  logic             play_start,
    output logic             index_lt_count,
    output logic             input_eq_pattern,
    output logic             is_legal,
    output logic             mem_full,
    output logic             play_busy,
    output logic             play_done,
    output logic [WIDTH-1:0] pattern_leds
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXT = (PLAY_TICKS > GAP_TICKS) ? PLAY_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [CW-1:0]    count;
    logic [CW-1:0]    index;
    logic [CW-1:0]    index_nx;
    logic             level_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] idx_mem;
    logic             one_hot;
    logic             wr_ok;

    assign play_busy = (state != IDLE);
    assign idx_mem   = mem[index[AW-1:0]];
    assign index_nx  = index + CW'(1);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign one_hot  = (pattern != '0) && ((pattern & (pattern - WIDTH'(1))) == '0);
    assign is_legal = level_q ? (pattern != '0) : one_hot;

    assign mem_full         = (count == CW'(DEPTH));
    assign index_lt_count   = (index < count);
    assign input_eq_pattern = index_lt_count && (pattern == idx_mem);

    assign wr_ok = w_en && is_legal && !mem_full && !play_busy;

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[count[AW-1:0]] <= pattern;
        end
    end

    always_comb begin
        pattern_leds = pattern;
        unique case (state)
            SHOW:    pattern_leds = idx_mem;
            GAP:     pattern_leds = '0;
            default: begin
                if (read_memory) begin
                    pattern_leds = (index < CW'(DEPTH)) ? idx_mem : '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            count     <= '0;
            index     <= '0;
            level_q   <= 1'b0;
            play_done <= 1'b0;
        end else begin
            play_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (set_level) begin
                        level_q <= level;
                    end
                    if (clr_count) begin
                        count <= '0;
                    end else if (cnt_count && !mem_full) begin
                        count <= count + CW'(1);
                    end
                    if (clr_index) begin
                        index <= '0;
                    end else if (cnt_index && index != CW'(DEPTH)) begin
                        index <= index_nx;
                    end
                    // An empty memory still answers with a done pulse.
                    if (play_start) begin
                        if (count != '0) begin
                            state <= SHOW;
                            timer <= '0;
                            index <= '0;
                        end else begin
                            play_done <= 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (timer == TW'(PLAY_TICKS - 1)) begin
                        state <= GAP;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    if (timer == TW'(GAP_TICKS - 1)) begin
                        timer <= '0;
                        index <= index_nx;
                        if (index_nx < count) begin
                            state <= SHOW;
                        end else begin
                            state     <= IDLE;
                            play_done <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_datapath_param.sv
// Bench for simon_datapath_param: cycle-level reference model plus
// hand-computed expectations for legality, saturation and replay timing.
module tb_simon_datapath_param;

    localparam int W = 4;
    localparam int D = 4;
    localparam int P = 2;
    localparam int G = 1;
    localparam int T = P + G;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         level;
    logic         set_level;
    logic [W-1:0] pattern;
    logic         w_en;
    logic         read_memory;
    logic         cnt_count;
    logic         clr_count;
    logic         cnt_index;
    logic         clr_index;
    logic         play_start;
    logic         index_lt_count;
    logic         input_eq_pattern;
    logic         is_legal;
    logic         mem_full;
    logic         play_busy;
    logic         play_done;
    logic [W-1:0] pattern_leds;

    simon_datapath_param #(
        .WIDTH(W), .DEPTH(D), .PLAY_TICKS(P), .GAP_TICKS(G)
    ) dut (
        .clk(clk), .reset(reset), .level(level), .set_level(set_level),
        .pattern(pattern), .w_en(w_en), .read_memory(read_memory),
        .cnt_count(cnt_count), .clr_count(clr_count),
        .cnt_index(cnt_index), .clr_index(clr_index),
        .play_start(play_start),
        .index_lt_count(index_lt_count), .input_eq_pattern(input_eq_pattern),
        .is_legal(is_legal), .mem_full(mem_full), .play_busy(play_busy),
        .play_done(play_done), .pattern_leds(pattern_leds)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: playback is a cycle offset into a count*T window.
    int           m_count, m_index, m_off, m_len;
    bit           m_level, m_busy, m_done;
    logic [W-1:0] m_mem [D];
    bit           m_valid [D];
    bit           chk_en = 1'b0;

    function automatic bit legal(logic [W-1:0] p, bit lv);
        return lv ? (p != 0) : ($countones(p) == 1);
    endfunction

    always @(posedge clk) begin
        int oc;
        oc     = m_count;
        m_done = 1'b0;
        if (reset) begin
            m_count = 0;
            m_index = 0;
            m_level = 1'b0;
            m_busy  = 1'b0;
        end else if (m_busy) begin
            m_off++;
            if (m_off == m_len) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_index = m_count;
            end else begin
                m_index = m_off / T;
            end
        end else begin
            if (w_en && legal(pattern, m_level) && oc < D) begin
                m_mem[oc]   = pattern;
                m_valid[oc] = 1'b1;
            end
            if (set_level) m_level = level;
            if (clr_count) m_count = 0;
            else if (cnt_count && m_count < D) m_count++;
            if (clr_index) m_index = 0;
            else if (cnt_index && m_index < D) m_index++;
            if (play_start) begin
                if (oc > 0) begin
                    m_busy  = 1'b1;
                    m_off   = 0;
                    m_len   = oc * T;
                    m_index = 0;
                end else begin
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit lt;
        int k;
        if (chk_en) begin
            lt = (m_index < m_count);
            check("index_lt_count", index_lt_count, lt);
            if (!lt) check("input_eq_pattern", input_eq_pattern, 0);
            else if (m_valid[m_index])
                check("input_eq_pattern", input_eq_pattern,
                      pattern === m_mem[m_index]);
            check("is_legal", is_legal, legal(pattern, m_level));
            check("mem_full", mem_full, m_count == D);
            check("play_busy", play_busy, m_busy);
            check("play_done", play_done, m_done);
            if (m_busy) begin
                k = m_off / T;
                if ((m_off % T) >= P) check("leds_gap", pattern_leds, 0);
                else if (m_valid[k]) check("leds_show", pattern_leds, m_mem[k]);
            end else if (!read_memory) begin
                check("leds_pattern", pattern_leds, pattern);
            end else if (m_index >= D) begin
                check("leds_mem_oob", pattern_leds, 0);
            end else if (m_valid[m_index]) begin
                check("leds_mem", pattern_leds, m_mem[m_index]);
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            set_level  = 1'b0;
            w_en       = 1'b0;
            cnt_count  = 1'b0;
            clr_count  = 1'b0;
            cnt_index  = 1'b0;
            clr_index  = 1'b0;
            play_start = 1'b0;
        end
    endtask

    logic [W-1:0] wr_pats [5];
    logic [W-1:0] exp_seq [9];
    logic [W-1:0] seq [9];
    int           nb;

    initial begin
        wr_pats = '{4'b0001, 4'b0100, 4'b1000, 4'b0010, 4'b1000};
        exp_seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100,
                    4'b0000, 4'b1000, 4'b1000, 4'b0000};
        reset = 1'b1; level = 1'b0; pattern = 4'b0010; read_memory = 1'b0;
        set_level = 1'b0; w_en = 1'b0; cnt_count = 1'b0; clr_count = 1'b0;
        cnt_index = 1'b0; clr_index = 1'b0; play_start = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_leds", pattern_leds, 4'b0010);
        check("rst_busy", play_busy, 0);
        check("rst_lt", index_lt_count, 0);
        check("rst_full", mem_full, 0);
        #1;
        reset   = 1'b0;
        pattern = 4'b0110;
        @(negedge clk);
        check("legal_easy_0110", is_legal, 0);
        #1;
        level = 1'b1; set_level = 1'b1;
        cyc();
        @(negedge clk);
        check("legal_hard_0110", is_legal, 1);
        #1;
        pattern = 4'b0000;
        @(negedge clk);
        check("legal_hard_zero", is_legal, 0);
        #1;
        level = 1'b0; set_level = 1'b1;
        cyc();
        @(negedge clk);
        check("legal_easy_zero", is_legal, 0);
        #1;

        for (int i = 0; i < 5; i++) begin
            pattern = wr_pats[i]; w_en = 1'b1; cnt_count = 1'b1;
            cyc();
            if (i == 3) begin
                @(negedge clk);
                check("full_after_4", mem_full, 1);
                #1;
            end
        end
        read_memory = 1'b1;
        @(negedge clk);
        check("fifth_not_stored", pattern_leds, 4'b0001);
        #1;
        read_memory = 1'b0;
        clr_count = 1'b1; cnt_count = 1'b1;
        cyc();
        @(negedge clk);
        check("clr_wins_full", mem_full, 0);
        #1;

        for (int i = 0; i < 3; i++) begin
            pattern = wr_pats[i]; w_en = 1'b1; cnt_count = 1'b1;
            cyc();
        end
        clr_index = 1'b1;
        cyc();
        pattern = 4'b0100; cnt_index = 1'b1;
        cyc();
        @(negedge clk);
        check("idx1_lt", index_lt_count, 1);
        check("idx1_eq", input_eq_pattern, 1);
        #1;
        cnt_index = 1'b1; cyc();
        cnt_index = 1'b1; cyc();
        @(negedge clk);
        check("idx3_lt", index_lt_count, 0);
        check("idx3_eq", input_eq_pattern, 0);
        #1;
        read_memory = 1'b1;
        @(negedge clk);
        check("idx3_leds_mem", pattern_leds, 4'b0010);
        #1;
        read_memory = 1'b0;

        play_start = 1'b1;
        cyc();
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!play_busy) break;
            if (nb < 9) seq[nb] = pattern_leds;
            nb++;
            #1;
            cnt_index = (i % 2 == 0);
            w_en      = 1'b1;
            clr_count = (i == 4);
            set_level = 1'b1;
            level     = 1'b1;
        end
        check("play_busy_len", nb, 9);
        check("play_done_pulse", play_done, 1);
        for (int i = 0; i < 9; i++) check($sformatf("play_led%0d", i), seq[i], exp_seq[i]);
        #1;
        cnt_index = 1'b0; w_en = 1'b0; clr_count = 1'b0;
        set_level = 1'b0; level = 1'b0;
        @(negedge clk);
        check("play_done_cleared", play_done, 0);
        check("play_exit_idx", index_lt_count, 0);
        #1;

        clr_count = 1'b1;
        cyc();
        play_start = 1'b1;
        cyc();
        @(negedge clk);
        check("empty_busy", play_busy, 0);
        check("empty_done", play_done, 1);
        @(negedge clk);
        check("empty_done_clr", play_done, 0);
        #1;

        cnt_count = 1'b1; cyc();
        cnt_count = 1'b1; cyc();
        cnt_count = 1'b1; cyc();
        play_start = 1'b1;
        cyc();
        @(negedge clk);
        check("abort_busy_before", play_busy, 1);
        #1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy_after", play_busy, 0);
        check("abort_no_done", play_done, 0);
        #1;
        cyc(4);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_datapath_param.md
# simon_datapath_param

Parametrised successor to the Simon datapath: stores the player-entered pattern sequence in an internal memory and tracks the stored-entry count and the replay/compare index. It enforces per-level legality rules and drives the pattern LEDs. It adds configurable LED width and memory depth, a full flag, and a self-timed playback engine that replays the stored sequence without controller stepping. It sits under the Simon control FSM, which drives its strobes and consumes its status flags.

## Interface
- WIDTH, 4, number of buttons/LEDs per pattern (≥2)
- DEPTH, 64, pattern memory entries (power of two, ≥2); AW = log2(DEPTH); count/index are AW+1 bits
- PLAY_TICKS, 8, cycles each entry is shown during playback (≥1)
- GAP_TICKS, 4, blank cycles after each shown entry (≥1)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- level  in  1  level value, captured when set_level=1
- set_level  in  1  load level register
- pattern  in  WIDTH  switch/button pattern
- w_en  in  1  write pattern to mem[count]
- read_memory  in  1  idle LED source select: 1 = mem[index], 0 = pattern
- cnt_count / clr_count  in  1  increment / clear count
- cnt_index / clr_index  in  1  increment / clear index
- play_start  in  1  start self-timed playback (one-cycle pulse)
- index_lt_count  out  1  index < count
- input_eq_pattern  out  1  index_lt_count && pattern == mem[index]
- is_legal  out  1  pattern legal for current level
- mem_full  out  1  count == DEPTH
- play_busy  out  1  playback engine active
- play_done  out  1  one-cycle pulse at playback end
- pattern_leds  out  WIDTH  LED drive

## Operation
- Level register: 0 = easy, is_legal iff exactly one pattern bit set; 1 = hard, is_legal iff pattern != 0. Combinational from pattern and level register.
- Write: w_en && is_legal && !mem_full writes mem[count[AW-1:0]] <= pattern. Otherwise ignored. Memory is not reset; read is asynchronous.
- count: clr_count → 0; else cnt_count → count+1, saturating at DEPTH. clr wins over cnt. Same for index (saturate at DEPTH).
- input_eq_pattern forced 0 when index ≥ count.
- Idle LEDs: read_memory ? (index < DEPTH ? mem[index] : 0) : pattern.
- Playback FSM, states IDLE, SHOW, GAP:
  - IDLE + play_start, count > 0: index ← 0, timer ← 0, go SHOW.
  - IDLE + play_start, count = 0: stay IDLE, play_done pulses next cycle.
  - SHOW: pattern_leds = mem[index]; after PLAY_TICKS cycles go GAP, timer ← 0.
  - GAP: pattern_leds = 0; after GAP_TICKS cycles index ← index+1. If index+1 < count, go SHOW; else go IDLE and pulse play_done.
  - play_busy = state != IDLE. On exit, index = count.
- While play_busy, w_en, cnt_/clr_count, cnt_/clr_index, set_level and play_start are ignored.
- reset (wins over everything): count=0, index=0, level=0, state IDLE, timer=0, play_done=0.

## Timing
- Reset outputs: index_lt_count=0, input_eq_pattern=0, mem_full=0, play_busy=0, play_done=0. pattern_leds = pattern, or mem[0] when read_memory=1. is_legal is a function of pattern under level 0.
- Register strobes take effect at the next rising edge. Status outputs reflect the new values in that cycle.
- A write at edge t is visible on reads from cycle t+1.
- play_start sampled at edge t:
  - play_busy is high from t+1.
  - Entry k is shown for PLAY_TICKS cycles starting at t+1+k·(PLAY_TICKS+GAP_TICKS).
  - Total busy time is count·(PLAY_TICKS+GAP_TICKS) cycles.
  - play_done is high for one cycle, the first cycle with play_busy=0.
- Reset asserted mid-playback returns to IDLE at the next edge with no play_done pulse.

## Test plan
- Reset → all flags 0, count/index 0; with read_memory=0 and pattern=4'b0010, pattern_leds=4'b0010.
- level=0, pattern=4'b0110 → is_legal=0. set_level with level=1 → is_legal=1. pattern=0 → is_legal=0 at both levels.
- DEPTH=4: write 5 legal patterns with w_en+cnt_count → mem_full=1 after the 4th. The 5th write is not stored and count stays 4. clr_count and cnt_count together → count 0.
- Store {0001,0100,1000}, clr_index, pattern=0100, cnt_index once → index_lt_count=1, input_eq_pattern=1. Step index to 3 → index_lt_count=0, input_eq_pattern=0.
- Same memory, PLAY_TICKS=2, GAP_TICKS=1, play_start → busy for 9 cycles. LEDs read 0001,0001,0000,0100,0100,0000,1000,1000,0000. Then play_done=1 for one cycle and index=3. cnt_index pulses during playback have no effect.
- play_start with count=0 → play_busy stays 0, play_done pulses one cycle later. Reset during SHOW → play_busy=0 next cycle, no play_done.
